// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: memory arbiter states,
// grant encoding and bus widths.
package mem_arbiter_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      ACC_I,
      ACC_D,
      DONE
   } mem_state_t;

   typedef enum logic {
      GNT_I,
      GNT_D
   } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// IF port, data port and external memory
// bus as seen by the memory arbiter.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
);

   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic [DATA_W-1:0] if_rdata_o;
   logic              if_done_o;

   logic              d_req_i;
   logic              d_we_i;
   logic [ADDR_W-1:0] d_addr_i;
   logic [DATA_W-1:0] d_wdata_i;
   logic [DATA_W-1:0] d_rdata_o;
   logic              d_done_o;

   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_rdata_i;

   logic              stall_o;

   modport master (
      input  if_req_i, if_addr_i,
      input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
      input  mem_ack_i, mem_rdata_i,
      output if_rdata_o, if_done_o,
      output d_rdata_o, d_done_o,
      output mem_req_o, mem_we_o,
      output mem_addr_o, mem_wdata_o,
      output stall_o
   );

   modport slave (
      output if_req_i, if_addr_i,
      output d_req_i, d_we_i, d_addr_i, d_wdata_i,
      output mem_ack_i, mem_rdata_i,
      input  if_rdata_o, if_done_o,
      input  d_rdata_o, d_done_o,
      input  mem_req_o, mem_we_o,
      input  mem_addr_o, mem_wdata_o,
      input  stall_o
   );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises IF fetches
// and MEM-stage loads/stores onto one memory port.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic          clk_i,
   input  logic          rst_i,
   mem_arbiter_if.master bus
);

   mem_state_t        state;
   grant_t            last_grant;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              if_done_q;
   logic              d_done_q;
   logic              pick_d;

   // Data wins a tie unless it won the previous one.
   assign pick_d = bus.d_req_i &
                   (~bus.if_req_i | (last_grant == GNT_I));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         last_grant  <= GNT_I;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
      end else begin
         if_done_q <= 1'b0;
         d_done_q  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pick_d) begin
                  state       <= ACC_D;
                  last_grant  <= GNT_D;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= bus.d_we_i;
                  mem_addr_q  <= bus.d_addr_i;
                  mem_wdata_q <= bus.d_wdata_i;
               end else if (bus.if_req_i) begin
                  state       <= ACC_I;
                  last_grant  <= GNT_I;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= bus.if_addr_i;
                  mem_wdata_q <= '0;
               end
            end
            ACC_I: begin
               if (bus.mem_ack_i) begin
                  state      <= DONE;
                  mem_req_q  <= 1'b0;
                  mem_we_q   <= 1'b0;
                  if_rdata_q <= bus.mem_rdata_i;
                  if_done_q  <= 1'b1;
               end
            end
            ACC_D: begin
               if (bus.mem_ack_i) begin
                  state     <= DONE;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  d_done_q  <= 1'b1;
                  if (!mem_we_q) begin
                     d_rdata_q <= bus.mem_rdata_i;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.d_rdata_o   = d_rdata_q;
   assign bus.if_done_o   = if_done_q;
   assign bus.d_done_o    = d_done_q;
   assign bus.stall_o     = (bus.if_req_i | bus.d_req_i) &
                            (state != DONE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one external memory between the pipeline's instruction-fetch (IF) port and the MEM-stage data port (loads/stores). It sits between the IF/MEM stages and the memory. It serialises accesses through a request/acknowledge FSM and returns read data to the requester that issued the access. While any request is outstanding it drives a pipeline-wide stall, which is ORed into the PC and IF_ID hold controls next to the hazard-detection stall.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; **one clock; reset is asynchronous and active-low**
- if_req_i  in  1  IF read request, level; held until if_done_o
- if_addr_i  in  ADDR_W  IF fetch address
- if_rdata_o  out  DATA_W  fetched word; held until next IF completion
- if_done_o  out  1  one-cycle IF completion pulse
- d_req_i  in  1  data request, level; held until d_done_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_rdata_o  out  DATA_W  load data; held until next data completion
- d_done_o  out  1  one-cycle data completion pulse
- mem_req_o  out  1  memory access request, registered
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address, registered
- mem_wdata_o  out  DATA_W  memory write data, registered
- mem_ack_i  in  1  memory completion; mem_rdata_i valid in the same cycle
- mem_rdata_i  in  DATA_W  memory read data
- stall_o  out  1  pipeline stall, combinational

## Operation
- FSM states: IDLE, ACC_I, ACC_D, DONE.
- IDLE:
  - Arbitrate among the requests present.
  - d_req_i only → ACC_D. if_req_i only → ACC_I.
  - Both present → ACC_D, unless last_grant == D; then → ACC_I.
  - On entry to an ACC state, latch address, we and wdata into the mem_* registers. Set mem_req_o=1 and update last_grant.
  - For IF accesses, mem_we_o=0 and mem_wdata_o=0.
- ACC_I / ACC_D:
  - Hold all mem_* outputs stable.
  - On mem_ack_i: clear mem_req_o and mem_we_o, register mem_rdata_i into the granted requester's rdata register, pulse its done, go to DONE.
  - Store completions also pulse d_done_o; d_rdata_o is left unchanged.
- DONE: one-cycle gap → IDLE. This lets the completed requester drop its req before the next arbitration.
- stall_o = (if_req_i | d_req_i) & ~(state == DONE). Deasserts exactly in the cycle the done pulse is visible.
- mem_ack_i is ignored outside the ACC states.
- A requester dropping req mid-access is a protocol violation. The access still completes and done still pulses.
- Reset values: state=IDLE, last_grant=I, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, if_rdata_o=0, d_rdata_o=0, if_done_o=0, d_done_o=0.
- stall_o during reset follows the request inputs.

## Timing
- Requests are sampled in cycle N (IDLE). mem_req_o is high from N+1.
- If mem_ack_i arrives in cycle N+k (k≥1), done and rdata appear in N+k+1 (DONE state).
- Next arbitration happens in N+k+2.
- Minimum turnaround is 3 cycles per access. Back-to-back D then I with 1-cycle memory: grants at N and N+3.
- Reset asserted mid-access: state and outputs clear asynchronously and mem_req_o falls immediately. A late ack after reset release is ignored in IDLE.
- No combinational path from mem_ack_i to mem_* outputs. done and rdata are registered.

## Structure
- Shared CPU package holds:
  - mem_state_t enum {IDLE, ACC_I, ACC_D, DONE}
  - grant_t {GNT_I, GNT_D}
  - MEM_ADDR_W / MEM_DATA_W constants
- Single module, with no sub-modules. The FSM, the latches and the two rdata registers are small enough to sit together.

## Test plan
- IF read, ack latency 1: if_addr_i=0x40, mem_rdata_i=0x8C220004 → mem_addr_o=0x40 at N+1, if_done_o pulse at N+2 with if_rdata_o=0x8C220004, stall_o low at N+2.
- Store: d_we_i=1, d_addr_i=0x10, d_wdata_i=0xDEADBEEF, ack latency 3 → mem_we_o=1 and stable for 3 cycles, d_done_o at N+4, d_rdata_o unchanged.
- Simultaneous if_req_i and d_req_i from reset (last_grant=I) → D served first, IF granted 3 cycles later. Repeat with last_grant=D → IF first.
- Spurious mem_ack_i in IDLE and in DONE → no done pulse, no register change.
- Reset (rst_i=0) during ACC_D with ack pending → mem_req_o drops immediately, all outputs at reset values. Ack after release → ignored, next request is served normally.
